// File: rtl/monitor_pkg.sv
`default_nettype none
// ============================================================================
// Package     : monitor_pkg
// Description : Shared types and constants for program_result_monitor.
//               Three-state FSM encoding (RUN / PASS / FAIL) and the
//               fail-cause code reported on fail_code.
// Revision    : 1.0  initial release
// ============================================================================
`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

package monitor_pkg;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t RUN  = 2'd0;
    localparam state_t PASS = 2'd1;
    localparam state_t FAIL = 2'd2;

    // Termination cause
    typedef enum logic [2:0] {
        NONE        = 3'd0,
        WRONG_VALUE = 3'd1,
        TIMEOUT     = 3'd2,
        FETCH_RANGE = 3'd3,
        PC_STUCK    = 3'd4,
        MISALIGNED  = 3'd5
    } fail_code_t;

endpackage

`default_nettype wire

// File: rtl/program_result_monitor_hang_detector.sv
`default_nettype none
// ============================================================================
// Module      : hang_detector
// Description : Fetch-address sanity checks for program_result_monitor.
//               Flags fetches beyond the program image, misaligned fetches,
//               and a PC that has not moved for STALL_LIMIT cycles.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               run_i           - monitor is in RUN; state advances only then
//               instr_adr_i     - current fetch byte address
//               range_err_o     - fetch address >= PROG_WORDS*4
//               misaligned_o    - fetch address not word aligned
//               stuck_o         - PC unchanged long enough to call it a hang
// Revision    : 1.0  initial release
// ============================================================================
module hang_detector #(
    parameter int PROG_WORDS  = 64,
    parameter int STALL_LIMIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_i,
    input  logic [31:0] instr_adr_i,
    output logic        range_err_o,
    output logic        misaligned_o,
    output logic        stuck_o
);

    // 33 bits so a large PROG_WORDS cannot wrap the byte limit
    localparam logic [32:0] PROG_BYTES = 33'(PROG_WORDS) * 33'd4;
    localparam logic [31:0] STALL_MAX  = 32'(STALL_LIMIT - 1);

    logic [31:0] prev_pc_q,  prev_pc_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        same_pc;

    assign same_pc      = (instr_adr_i == prev_pc_q);
    assign range_err_o  = ({1'b0, instr_adr_i} >= PROG_BYTES);
    assign misaligned_o = (instr_adr_i[1:0] != 2'b00);
    assign stuck_o      = same_pc && (stall_cnt_q == STALL_MAX);

    always_comb begin
        prev_pc_d   = prev_pc_q;
        stall_cnt_d = stall_cnt_q;
        if (run_i) begin
            prev_pc_d   = instr_adr_i;
            stall_cnt_d = same_pc ? stall_cnt_q + 32'd1 : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_pc_q   <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            prev_pc_q   <= prev_pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/program_result_monitor.sv
`default_nettype none
// ============================================================================
// Module      : program_result_monitor
// Description : End-of-program checker. Watches the data-memory write port
//               for the result store and the fetch address for hangs, then
//               latches a sticky done/pass verdict with a cause code.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               mem_en, mem_write_en, mem_adr, mem_write_data - store port
//               instr_adr       - current fetch byte address (PC)
//               done, pass      - sticky verdict (pass valid with done)
//               fail_code       - termination cause (monitor_pkg::fail_code_t)
//               result_value    - data of the terminating result store
//               cycle_count     - RUN cycles, frozen at termination
//               instr_number    - (instr_adr>>2)+1, frozen at termination
// Revision    : 1.0  initial release
// ============================================================================
`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

module program_result_monitor
    import monitor_pkg::*;
#(
    parameter int                 DATA_W         = `BIT_COUNT,
    parameter logic [31:0]        RESULT_ADDR    = 32'hC,
    parameter logic [DATA_W-1:0]  EXPECTED       = DATA_W'(15),
    parameter int                 PROG_WORDS     = 64,
    parameter int                 TIMEOUT_CYCLES = 10000,
    parameter int                 STALL_LIMIT    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_en,
    input  logic              mem_write_en,
    input  logic [31:0]       mem_adr,
    input  logic [DATA_W-1:0] mem_write_data,
    input  logic [31:0]       instr_adr,
    output logic              done,
    output logic              pass,
    output logic [2:0]        fail_code,
    output logic [DATA_W-1:0] result_value,
    output logic [31:0]       cycle_count,
    output logic [31:0]       instr_number
);

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t            state_q,  state_d;
    logic [2:0]        fail_q,   fail_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [31:0]       cycle_q,  cycle_d;
    logic [31:0]       instr_q,  instr_d;

    logic run;
    logic result_store;
    logic range_err;
    logic misaligned;
    logic stuck;

    assign run          = (state_q == RUN);
    assign result_store = mem_en && mem_write_en && (mem_adr == RESULT_ADDR);

    hang_detector #(
        .PROG_WORDS  (PROG_WORDS),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_hang_detector (
        .clk          (clk),
        .reset        (reset),
        .run_i        (run),
        .instr_adr_i  (instr_adr),
        .range_err_o  (range_err),
        .misaligned_o (misaligned),
        .stuck_o      (stuck)
    );

    // Events are evaluated in strict priority; a result store beats every
    // hang condition seen in the same cycle.
    always_comb begin
        state_d  = state_q;
        fail_d   = fail_q;
        result_d = result_q;
        cycle_d  = cycle_q;
        instr_d  = instr_q;
        if (run) begin
            cycle_d = (cycle_q == 32'hFFFF_FFFF) ? cycle_q : cycle_q + 32'd1;
            instr_d = (instr_adr >> 2) + 32'd1;
            if (result_store) begin
                result_d = mem_write_data;
                if (mem_write_data == EXPECTED) begin
                    state_d = PASS;
                    fail_d  = NONE;
                end else begin
                    state_d = FAIL;
                    fail_d  = WRONG_VALUE;
                end
            end else if (range_err) begin
                state_d = FAIL;
                fail_d  = FETCH_RANGE;
            end else if (misaligned) begin
                state_d = FAIL;
                fail_d  = MISALIGNED;
            end else if (stuck) begin
                state_d = FAIL;
                fail_d  = PC_STUCK;
            end else if (cycle_q == TIMEOUT_LAST) begin
                state_d = FAIL;
                fail_d  = TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            fail_q   <= NONE;
            result_q <= '0;
            cycle_q  <= 32'd0;
            instr_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            fail_q   <= fail_d;
            result_q <= result_d;
            cycle_q  <= cycle_d;
            instr_q  <= instr_d;
        end
    end

    assign done         = (state_q != RUN);
    assign pass         = (state_q == PASS);
    assign fail_code    = fail_q;
    assign result_value = result_q;
    assign cycle_count  = cycle_q;
    assign instr_number = instr_q;

endmodule

`default_nettype wire

// File: tb/tb_program_result_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_result_monitor
// Description : Directed self-checking bench for program_result_monitor.
// Revision    : 1.0  initial release
// ============================================================================
module tb_program_result_monitor;

    logic        clk;
    logic        reset;
    logic        mem_en;
    logic        mem_write_en;
    logic [31:0] mem_adr;
    logic [31:0] mem_write_data;
    logic [31:0] instr_adr;
    logic        done;
    logic        pass;
    logic [2:0]  fail_code;
    logic [31:0] result_value;
    logic [31:0] cycle_count;
    logic [31:0] instr_number;

    int errors = 0;
    int checks = 0;

    program_result_monitor #(
        .DATA_W         (32),
        .RESULT_ADDR    (32'hC),
        .EXPECTED       (32'h0F),
        .PROG_WORDS     (64),
        .TIMEOUT_CYCLES (100),
        .STALL_LIMIT    (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_en         (mem_en),
        .mem_write_en   (mem_write_en),
        .mem_adr        (mem_adr),
        .mem_write_data (mem_write_data),
        .instr_adr      (instr_adr),
        .done           (done),
        .pass           (pass),
        .fail_code      (fail_code),
        .result_value   (result_value),
        .cycle_count    (cycle_count),
        .instr_number   (instr_number)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        mem_en         = 1'b0;
        mem_write_en   = 1'b0;
        mem_adr        = 32'd0;
        mem_write_data = 32'd0;
    endtask

    task automatic do_reset();
        idle_bus();
        instr_adr = 32'd0;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
    endtask

    task automatic store(input logic [31:0] adr, input logic [31:0] data);
        mem_en         = 1'b1;
        mem_write_en   = 1'b1;
        mem_adr        = adr;
        mem_write_data = data;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (done !== 1'b0)          begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (pass !== 1'b0)          begin errors++; $display("FAIL reset_pass got=%0b exp=0", pass); end
        checks++; if (fail_code !== 3'd0)     begin errors++; $display("FAIL reset_code got=%0d exp=0", fail_code); end
        checks++; if (result_value !== 32'd0) begin errors++; $display("FAIL reset_value got=%h exp=0", result_value); end
        checks++; if (cycle_count !== 32'd0)  begin errors++; $display("FAIL reset_cycles got=%0d exp=0", cycle_count); end
        checks++; if (instr_number !== 32'd0) begin errors++; $display("FAIL reset_instr got=%0d exp=0", instr_number); end
    endtask

    task automatic test_pass();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            instr_adr = 32'(i * 4);
            tick();
        end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL pass_early_done got=%0b exp=0", done); end
        instr_adr = 32'h50;
        store(32'hC, 32'h0F);
        tick();
        idle_bus();
        checks++; if (done !== 1'b1)          begin errors++; $display("FAIL pass_done got=%0b exp=1", done); end
        checks++; if (pass !== 1'b1)          begin errors++; $display("FAIL pass_pass got=%0b exp=1", pass); end
        checks++; if (fail_code !== 3'd0)     begin errors++; $display("FAIL pass_code got=%0d exp=0", fail_code); end
        checks++; if (result_value !== 32'h0F) begin errors++; $display("FAIL pass_value got=%h exp=0f", result_value); end
        checks++; if (cycle_count !== 32'd21) begin errors++; $display("FAIL pass_cycles got=%0d exp=21", cycle_count); end
        checks++; if (instr_number !== 32'd21) begin errors++; $display("FAIL pass_instr got=%0d exp=21", instr_number); end
        // Terminal state must ignore further traffic, including bad fetches.
        for (int i = 0; i < 50; i++) begin
            instr_adr = (i % 2 == 0) ? 32'h103 : 32'h8;
            store(32'hC, 32'h0E);
            tick();
            checks++;
            if (done !== 1'b1 || pass !== 1'b1 || fail_code !== 3'd0 ||
                result_value !== 32'h0F || cycle_count !== 32'd21 || instr_number !== 32'd21) begin
                errors++;
                $display("FAIL pass_hold cyc=%0d got done=%0b pass=%0b code=%0d val=%h cnt=%0d ins=%0d exp 1 1 0 0f 21 21",
                         i, done, pass, fail_code, result_value, cycle_count, instr_number);
            end
        end
        idle_bus();
    endtask

    task automatic test_wrong_value();
        do_reset();
        tick();
        store(32'hC, 32'h0E);
        tick();
        idle_bus();
        checks++; if (done !== 1'b1)           begin errors++; $display("FAIL wrong_done got=%0b exp=1", done); end
        checks++; if (pass !== 1'b0)           begin errors++; $display("FAIL wrong_pass got=%0b exp=0", pass); end
        checks++; if (fail_code !== 3'd1)      begin errors++; $display("FAIL wrong_code got=%0d exp=1", fail_code); end
        checks++; if (result_value !== 32'h0E) begin errors++; $display("FAIL wrong_value got=%h exp=0e", result_value); end
    endtask

    task automatic test_no_effect();
        do_reset();
        instr_adr = 32'h4;
        store(32'h10, 32'h0F);
        tick();
        instr_adr = 32'h8;
        store(32'hC, 32'h0F);
        mem_write_en = 1'b0;
        tick();
        instr_adr = 32'hC;
        store(32'hC, 32'h0F);
        mem_en = 1'b0;
        tick();
        idle_bus();
        checks++; if (done !== 1'b0)          begin errors++; $display("FAIL noeffect_done got=%0b exp=0", done); end
        checks++; if (result_value !== 32'd0) begin errors++; $display("FAIL noeffect_value got=%h exp=0", result_value); end
        checks++; if (cycle_count !== 32'd3)  begin errors++; $display("FAIL noeffect_cycles got=%0d exp=3", cycle_count); end
    endtask

    task automatic test_priority();
        do_reset();
        instr_adr = 32'h100;
        store(32'hC, 32'h0F);
        tick();
        idle_bus();
        checks++; if (pass !== 1'b1 || fail_code !== 3'd0) begin
            errors++; $display("FAIL prio_store got pass=%0b code=%0d exp pass=1 code=0", pass, fail_code);
        end
    endtask

    task automatic test_range();
        do_reset();
        instr_adr = 32'hFC;
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL range_last_ok got done=%0b exp=0", done); end
        instr_adr = 32'h100;
        tick();
        checks++; if (done !== 1'b1 || pass !== 1'b0 || fail_code !== 3'd3) begin
            errors++; $display("FAIL range_code got done=%0b pass=%0b code=%0d exp 1 0 3", done, pass, fail_code);
        end
        checks++; if (instr_number !== 32'd65) begin errors++; $display("FAIL range_instr got=%0d exp=65", instr_number); end
    endtask

    task automatic test_misaligned();
        do_reset();
        instr_adr = 32'h6;
        tick();
        checks++; if (done !== 1'b1 || fail_code !== 3'd5) begin
            errors++; $display("FAIL misaligned_code got done=%0b code=%0d exp 1 5", done, fail_code);
        end
    endtask

    task automatic test_stuck();
        do_reset();
        instr_adr = 32'h20;
        // Edge 1 compares against the reset prev-PC of 0; edges 2..17 repeat.
        for (int e = 1; e <= 16; e++) begin
            tick();
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL stuck_early edge=%0d got done=%0b exp=0", e, done); end
        end
        tick();
        checks++; if (done !== 1'b1 || fail_code !== 3'd4) begin
            errors++; $display("FAIL stuck_code got done=%0b code=%0d exp 1 4", done, fail_code);
        end
        checks++; if (cycle_count !== 32'd17) begin errors++; $display("FAIL stuck_cycles got=%0d exp=17", cycle_count); end
        checks++; if (instr_number !== 32'd9) begin errors++; $display("FAIL stuck_instr got=%0d exp=9", instr_number); end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int e = 1; e <= 99; e++) begin
            instr_adr = (e % 2 == 1) ? 32'h20 : 32'h24;
            tick();
        end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL timeout_early got done=%0b exp=0", done); end
        instr_adr = 32'h20;
        tick();
        checks++; if (done !== 1'b1 || fail_code !== 3'd2) begin
            errors++; $display("FAIL timeout_code got done=%0b code=%0d exp 1 2", done, fail_code);
        end
        checks++; if (cycle_count !== 32'd100) begin errors++; $display("FAIL timeout_cycles got=%0d exp=100", cycle_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        instr_adr = 32'h6;
        tick();
        instr_adr = 32'h8;
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL midrst_setup got done=%0b exp=1", done); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (done !== 1'b0 || pass !== 1'b0 || fail_code !== 3'd0 || result_value !== 32'd0 ||
                      cycle_count !== 32'd0 || instr_number !== 32'd0) begin
            errors++; $display("FAIL midrst_clear got done=%0b pass=%0b code=%0d val=%h cnt=%0d ins=%0d exp all 0",
                               done, pass, fail_code, result_value, cycle_count, instr_number);
        end
        instr_adr = 32'h0;
        store(32'hC, 32'h0F);
        tick();
        idle_bus();
        checks++; if (done !== 1'b1 || pass !== 1'b1 || cycle_count !== 32'd1) begin
            errors++; $display("FAIL midrst_pass got done=%0b pass=%0b cnt=%0d exp 1 1 1", done, pass, cycle_count);
        end
    endtask

    initial begin
        reset     = 1'b1;
        instr_adr = 32'd0;
        idle_bus();
        test_reset();
        test_pass();
        test_wrong_value();
        test_no_effect();
        test_priority();
        test_range();
        test_misaligned();
        test_stuck();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
